// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Defining UART_PARITY_EN adds the even-parity state to both FSMs.
package uart_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_t;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: registered pointers with an extra wrap bit to tell full from empty.
// When empty, the read port holds the last word popped.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic             overrun_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] last_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  // A pop frees the slot being written, so push-while-full succeeds in that cycle.
  assign do_push = push_i & (~full | do_pop);

  assign overrun_o = push_i & full & ~do_pop;
  assign valid_o   = ~empty;
  assign rdata_o   = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX serialiser, synchronised RX deserialiser, receive FIFO.
// Optional even parity on both paths when UART_PARITY_EN is defined.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 500_000_000,
  parameter int unsigned BAUD_RATE       = 115_200,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned RX_FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_OVERRUN,
  output logic                 UART_TX_DSER,
  input  logic                 UART_RX_DSER
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8) begin : g_cpb_check
    $error("uart_transceiver: CLOCK_FREQUENCY / BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_width_check
    $error("uart_transceiver: DATA_BITS must be 5..9");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_transceiver: RX_FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------- Transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_bit_end   = (tx_cnt_q == BIT_LAST);
  assign TX_READY     = (tx_state_q == TxIdle);
  assign UART_TX_DSER = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != TxIdle) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end
    unique case (tx_state_q)
      TxIdle: begin
        if (TX_VALID) begin
          tx_state_d = TxStart;
          tx_shift_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = ^TX_DATA;
`endif
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_idx_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          if (tx_idx_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = TxParity;
            tx_line_d  = tx_par_q;
`else
            tx_state_d = TxStop;
            tx_line_d  = 1'b1;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_line_d  = 1'b1;
        end
      end
`endif
      TxStop: begin
        if (tx_bit_end) begin
          tx_state_d = TxIdle;
        end
      end
      default: begin
        tx_state_d = TxIdle;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------- Receiver ----------------
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_in, rx_prev_q, rx_fall;
  rx_state_t              rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_bit_end, rx_push, rx_par_ok;
  logic                   frame_err_d, frame_err_q, fifo_overrun, overrun_q;
`ifdef UART_PARITY_EN
  logic                   rx_par_ok_q, rx_par_ok_d;
  assign rx_par_ok = rx_par_ok_q;
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_in      = rx_sync_q[SYNC_STAGES-1];
  assign rx_fall    = rx_prev_q & ~rx_in;
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ok_d = rx_par_ok_q;
`endif
    if (rx_state_q != RxIdle) begin
      rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start check; a high line here was a glitch and is dropped silently.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_in ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (rx_bit_end) begin
          rx_par_ok_d = (rx_in == ^rx_shift_q);
          rx_state_d  = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_bit_end) begin
          rx_state_d = RxIdle;
          if (rx_in && rx_par_ok) begin
            rx_push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sync_q   <= '1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok_q <= 1'b0;
`endif
    end else begin
      rx_sync_q   <= {rx_sync_q[SYNC_STAGES-2:0], UART_RX_DSER};
      rx_prev_q   <= rx_in;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= fifo_overrun;
`ifdef UART_PARITY_EN
      rx_par_ok_q <= rx_par_ok_d;
`endif
    end
  end

  assign RX_FRAME_ERR = frame_err_q;
  assign RX_OVERRUN   = overrun_q;

  uart_rx_fifo #(
    .Width (DATA_BITS),
    .Depth (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .push_i    (rx_push),
    .wdata_i   (rx_shift_q),
    .pop_i     (RX_READY),
    .rdata_o   (RX_DATA),
    .valid_o   (RX_VALID),
    .overrun_o (fifo_overrun)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: 16 clk/bit, TX looped to RX unless a test drives the line.
// Parity scenarios are included when UART_PARITY_EN is defined.
module tb_uart_transceiver;

  localparam int unsigned CPB = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_LEN = 11;
`else
  localparam int unsigned FRAME_LEN = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY = 1'b0;
  logic       RX_FRAME_ERR;
  logic       RX_OVERRUN;
  logic       UART_TX_DSER;
  logic       rx_line;
  logic       loop_en = 1'b1;
  logic       drv_line = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int frame_err_cnt = 0;
  int overrun_cnt = 0;

  assign rx_line = loop_en ? UART_TX_DSER : drv_line;

  always #5 CLK = ~CLK;

  // Counts high cycles, so a pulse longer than one cycle shows as an extra count.
  always @(posedge CLK) begin
    if (RX_FRAME_ERR) frame_err_cnt <= frame_err_cnt + 1;
    if (RX_OVERRUN) overrun_cnt <= overrun_cnt + 1;
  end

  uart_transceiver #(
    .CLOCK_FREQUENCY (16_000_000),
    .BAUD_RATE       (1_000_000),
    .DATA_BITS       (8),
    .RX_FIFO_DEPTH   (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .TX_DATA      (TX_DATA),
    .TX_VALID     (TX_VALID),
    .TX_READY     (TX_READY),
    .RX_DATA      (RX_DATA),
    .RX_VALID     (RX_VALID),
    .RX_READY     (RX_READY),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .RX_OVERRUN   (RX_OVERRUN),
    .UART_TX_DSER (UART_TX_DSER),
    .UART_RX_DSER (rx_line)
  );

  // Handshake lands on the posedge just before return; TX_DATA is then scrambled.
  task automatic send_byte(input logic [7:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (TX_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      TX_DATA  = data;
      TX_VALID = 1'b1;
      @(posedge CLK);
      #1;
      TX_VALID = 1'b0;
      TX_DATA  = ~data;
    end
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      if (RX_VALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_one();
    @(negedge CLK);
    RX_READY = 1'b1;
    @(posedge CLK);
    #1;
    RX_READY = 1'b0;
  endtask

  // bits[0] goes on the line first.
  task automatic drive_bits(input logic [15:0] bits, input int len);
    loop_en = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < len; i++) begin
      drv_line = bits[i];
      repeat (CPB) @(posedge CLK);
    end
    drv_line = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (UART_TX_DSER !== 1'b1) begin n_fail++; $display("FAIL reset_tx_line got=%b want=1", UART_TX_DSER); end
    n_checks++;
    if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b want=1", TX_READY); end
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b want=0", RX_VALID); end
    n_checks++;
    if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h want=00", RX_DATA); end
    n_checks++;
    if (RX_FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b want=0", RX_FRAME_ERR); end
    n_checks++;
    if (RX_OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b want=0", RX_OVERRUN); end
  endtask

  task automatic test_single_a5();
    bit ok;
    int fe0 = frame_err_cnt;
    int ov0 = overrun_cnt;
`ifdef UART_PARITY_EN
    logic exp_line [FRAME_LEN] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    logic exp_line [FRAME_LEN] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    send_byte(8'hA5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL a5_send_ready got=timeout want=TX_READY"); end
    repeat (8) @(posedge CLK);
    #1;
    n_checks++;
    if (TX_READY !== 1'b0) begin n_fail++; $display("FAIL a5_tx_busy got=%b want=0", TX_READY); end
    for (int k = 0; k < FRAME_LEN; k++) begin
      n_checks++;
      if (UART_TX_DSER !== exp_line[k])
        begin n_fail++; $display("FAIL a5_line_bit%0d got=%b want=%b", k, UART_TX_DSER, exp_line[k]); end
      repeat (CPB) @(posedge CLK);
      #1;
    end
    wait_valid(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL a5_rx_valid got=0 want=1"); end
    n_checks++;
    if (RX_DATA !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_data got=%h want=a5", RX_DATA); end
    n_checks++;
    if (frame_err_cnt !== fe0) begin n_fail++; $display("FAIL a5_no_frame_err got=%0d want=%0d", frame_err_cnt, fe0); end
    n_checks++;
    if (overrun_cnt !== ov0) begin n_fail++; $display("FAIL a5_no_overrun got=%0d want=%0d", overrun_cnt, ov0); end
    pop_one();
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL a5_pop_empty got=%b want=0", RX_VALID); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] bytes [5] = '{8'h00, 8'hFF, 8'h5A, 8'h3C, 8'h81};
    int ov0 = overrun_cnt;
    int fe0 = frame_err_cnt;
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_send%0d got=timeout want=TX_READY", i); end
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (TX_READY) break;
    end
    repeat (30) @(posedge CLK);
    #1;
    n_checks++;
    if (overrun_cnt !== ov0 + 1) begin n_fail++; $display("FAIL b2b_overrun_pulse got=%0d want=%0d", overrun_cnt, ov0 + 1); end
    n_checks++;
    if (frame_err_cnt !== fe0) begin n_fail++; $display("FAIL b2b_no_frame_err got=%0d want=%0d", frame_err_cnt, fe0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d got=%b want=1", i, RX_VALID); end
      n_checks++;
      if (RX_DATA !== bytes[i]) begin n_fail++; $display("FAIL b2b_data%0d got=%h want=%h", i, RX_DATA, bytes[i]); end
      pop_one();
    end
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%b want=0", RX_VALID); end
  endtask

  task automatic test_glitch();
    bit ok;
    int fe0 = frame_err_cnt;
    int ov0 = overrun_cnt;
    loop_en = 1'b0;
    @(negedge CLK);
    drv_line = 1'b0;
    repeat (5) @(posedge CLK);
    drv_line = 1'b1;
    repeat (60) @(posedge CLK);
    #1;
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL glitch_no_valid got=%b want=0", RX_VALID); end
    n_checks++;
    if (frame_err_cnt !== fe0) begin n_fail++; $display("FAIL glitch_no_frame_err got=%0d want=%0d", frame_err_cnt, fe0); end
    n_checks++;
    if (overrun_cnt !== ov0) begin n_fail++; $display("FAIL glitch_no_overrun got=%0d want=%0d", overrun_cnt, ov0); end
    loop_en = 1'b1;
    send_byte(8'h3C, ok);
    wait_valid(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL glitch_recover_valid got=0 want=1"); end
    n_checks++;
    if (RX_DATA !== 8'h3C) begin n_fail++; $display("FAIL glitch_recover_data got=%h want=3c", RX_DATA); end
    pop_one();
  endtask

  task automatic test_frame_err();
    int fe0 = frame_err_cnt;
`ifdef UART_PARITY_EN
    drive_bits({5'b0, 1'b0, 1'b0, 8'h55, 1'b0}, FRAME_LEN);
`else
    drive_bits({6'b0, 1'b0, 8'h55, 1'b0}, FRAME_LEN);
`endif
    repeat (30) @(posedge CLK);
    #1;
    n_checks++;
    if (frame_err_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d want=%0d", frame_err_cnt, fe0 + 1); end
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ferr_fifo_empty got=%b want=0", RX_VALID); end
    loop_en = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    bit ok;
    int fe0;
    send_byte(8'h07, ok);
    repeat (8 + 9 * CPB) @(posedge CLK);
    #1;
    n_checks++;
    if (UART_TX_DSER !== 1'b1) begin n_fail++; $display("FAIL par_tx_bit got=%b want=1", UART_TX_DSER); end
    wait_valid(200, ok);
    n_checks++;
    if (!ok || RX_DATA !== 8'h07) begin n_fail++; $display("FAIL par_rx_data got=%h want=07", RX_DATA); end
    pop_one();
    fe0 = frame_err_cnt;
    drive_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, FRAME_LEN);
    repeat (30) @(posedge CLK);
    #1;
    n_checks++;
    if (frame_err_cnt !== fe0 + 1) begin n_fail++; $display("FAIL par_bad_err got=%0d want=%0d", frame_err_cnt, fe0 + 1); end
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL par_bad_no_push got=%b want=0", RX_VALID); end
    loop_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int fe0;
    send_byte(8'h66, ok);
    wait_valid(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_prefill got=0 want=1"); end
    send_byte(8'hC3, ok);
    // Mid data bit 3: start bit plus three data bits plus half a bit past the handshake edge.
    repeat (72) @(posedge CLK);
    #1;
    n_checks++;
    if (UART_TX_DSER !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3 got=%b want=0", UART_TX_DSER); end
    RST = 1'b1;
    #1;
    n_checks++;
    if (UART_TX_DSER !== 1'b1) begin n_fail++; $display("FAIL rstmid_line_high got=%b want=1", UART_TX_DSER); end
    n_checks++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifo_flush got=%b want=0", RX_VALID); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    fe0 = frame_err_cnt;
    @(posedge CLK);
    #1;
    n_checks++;
    if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready got=%b want=1", TX_READY); end
    n_checks++;
    if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data got=%h want=00", RX_DATA); end
    repeat (250) @(posedge CLK);
    #1;
    n_checks++;
    if (RX_VALID !== 1'b0 || UART_TX_DSER !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_idle got=valid%b/line%b want=valid0/line1", RX_VALID, UART_TX_DSER); end
    n_checks++;
    if (frame_err_cnt !== fe0) begin n_fail++; $display("FAIL rstmid_no_err got=%0d want=%0d", frame_err_cnt, fe0); end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_glitch();
    test_frame_err();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART for the RV32I MCU: TX serialiser and RX deserialiser with a receive FIFO, valid/ready byte interfaces toward the bus-side register block, and serial pins matching the MCU top-level UART_TX_DSER / UART_RX_DSER. It generalises the fixed 8N1 path with configurable data width, baud, FIFO depth, optional parity and error reporting, and is the UART instance the MCU top drives in TX→RX loopback benches.

## Interface
- CLOCK_FREQUENCY, 500_000_000, CLK frequency in Hz
- BAUD_RATE, 115_200, line rate in bit/s
- DATA_BITS, 8, payload bits per frame, legal 5..9
- RX_FIFO_DEPTH, 4, receive FIFO entries, power of two ≥ 2
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- TX_DATA  in  DATA_BITS  byte to transmit
- TX_VALID  in  1  TX_DATA valid
- TX_READY  out  1  transmitter idle, accepts TX_DATA
- RX_DATA  out  DATA_BITS  head of RX FIFO
- RX_VALID  out  1  RX FIFO not empty
- RX_READY  in  1  consumer pops head when RX_VALID high
- RX_FRAME_ERR  out  1  one-cycle pulse, stop bit sampled low
- RX_OVERRUN  out  1  one-cycle pulse, frame dropped because FIFO full
- UART_TX_DSER  out  1  serial output, idle high
- UART_RX_DSER  in  1  serial input, asynchronous to CLK

## Operation
- CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE, truncated; elaboration error if < 8. Half-bit = CLKS_PER_BIT/2, truncated.
- Frame: start (0), DATA_BITS LSB first, optional parity, one stop (1).
- TX FSM: TX_IDLE → TX_START → TX_DATA → [TX_PARITY] → TX_STOP → TX_IDLE; each state holds line for exactly CLKS_PER_BIT cycles. TX_READY = (state == TX_IDLE). Handshake TX_VALID & TX_READY latches TX_DATA; TX_DATA may change afterwards.
- RX: UART_RX_DSER through 2-flop synchroniser (reset to 1). RX FSM: RX_IDLE → RX_START on synchronised 1→0; in RX_START wait half-bit, if line high return to RX_IDLE (glitch, no flag); else RX_DATA sampling each bit at CLKS_PER_BIT intervals (mid-bit), then [RX_PARITY], RX_STOP.
- RX_STOP sample high → push to FIFO; low → RX_FRAME_ERR pulse, frame discarded. FSM returns to RX_IDLE after stop sample, not after full stop period.
- FIFO full at push → RX_OVERRUN pulse, frame discarded, FIFO contents unchanged. Push and pop in same cycle while full → both occur, no overrun. Pop when empty ignored.
- RX_DATA shows FIFO head combinationally from storage; undefined-free: holds last value when empty.
- Reset mid-frame: both FSMs abort to idle, UART_TX_DSER forced high immediately, FIFO emptied.

## Timing
- Reset values: UART_TX_DSER=1, TX_READY=1, RX_VALID=0, RX_DATA=0, RX_FRAME_ERR=0, RX_OVERRUN=0.
- TX: handshake in cycle n → UART_TX_DSER low from cycle n+1 (registered output). TX_READY low from n+1 until frame end; back-to-back frames allowed with zero idle gap.
- RX: word visible (RX_VALID high) 1 cycle after stop-bit sample; start edge to stop sample = 2 sync + half-bit + (DATA_BITS[+1]+1)·CLKS_PER_BIT cycles.
- Pop: RX_VALID & RX_READY in cycle n → next head (or RX_VALID=0) in n+1.

## Configuration
- UART_PARITY_EN defined: even parity bit after data on TX; RX checks it, mismatch → frame discarded and RX_FRAME_ERR pulses at stop sample (shared flag). Frame length DATA_BITS+3.
- Undefined: no parity state in either FSM, frame length DATA_BITS+2.

## Structure
- uart_pkg: tx_state_t, rx_state_t enums, clks_per_bit() function, SYNC_STAGES=2 constant.
- Sub-module uart_rx_fifo (parametrised width/depth, registered pointers, extra wrap bit for full/empty); TX/RX FSMs inline in uart_transceiver.

## Test plan
Bench: CLOCK_FREQUENCY=16_000_000, BAUD_RATE=1_000_000 (16 clk/bit), DATA_BITS=8, TX looped to RX.
- Send 0xA5 → line 0,1,0,1,0,0,1,0,1,1 at 16-cycle bit times; RX_DATA=0xA5, RX_VALID high, no flags.
- Send 0x00,0xFF,0x5A,0x3C back-to-back, RX_READY=0 → FIFO holds 4; fifth frame 0x81 → RX_OVERRUN pulse, pops return 0x00,0xFF,0x5A,0x3C.
- Force RX line low 5 cycles then high → no RX_VALID, no flag, RX returns to idle.
- Drive frame 0x55 with stop bit 0 → RX_FRAME_ERR one-cycle pulse, FIFO stays empty.
- Assert RST at TX bit 3 of 0xC3 → UART_TX_DSER=1 same cycle, TX_READY=1 after release, FIFO empty.
- With UART_PARITY_EN: 0x07 sends parity 1; inject flipped parity → RX_FRAME_ERR, no push.
